// File: rtl/cpu_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mon_pkg
//  Description : Shared types and constants for the CPU run monitor: the
//                run-control state encoding, default halt encodings and the
//                run-cycle counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_mon_pkg;

    // Run-control state encoding. The parent FSM uses IDLE..DRAIN, DONE and
    // DUMP_RD (meaning "dump in progress"); the scanner uses IDLE and the
    // three DUMP_* states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_DUMP_OUT  = 3'd6,
        ST_DONE      = 3'd7
    } cpu_mon_state_e;

    // Default halt encodings of the 16-bit core
    localparam logic [15:0] c_HALT_OP_A_DEFAULT = 16'hE000;
    localparam logic [15:0] c_HALT_OP_B_DEFAULT = 16'hE7FF;

    // Width of the saturating RUN-cycle counter
    localparam int c_CYCLE_W = 32;

endpackage : cpu_mon_pkg
`default_nettype wire

// File: rtl/cpu_mon_dump_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mon_dump_scanner
//  Description : Data-memory scanner. On a go pulse it reads addresses
//                0..DUMP_DEPTH-1 through a one-cycle-latency read port and
//                presents each word on a valid/ready port. Zero words are
//                skipped unless CPU_MON_DUMP_ALL_EN is defined, in which case
//                every address is emitted. Pulses finished (combinationally)
//                on the cycle the last address is retired.
//  Config      : CPU_MON_DUMP_ALL_EN - emit every word, zeros included
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mon_dump_scanner
    import cpu_mon_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DUMP_DEPTH = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    output logic              finished,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DUMP_DEPTH - 1);

    cpu_mon_state_e    r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_dump_addr;
    logic [DATA_W-1:0] r_dump_data;

    logic w_skip;
    logic w_last;
    logic w_advance;

    // Decide whether the word returned this cycle is dropped
`ifdef CPU_MON_DUMP_ALL_EN
    always_comb begin
        w_skip = 1'b0;
    end
`else
    always_comb begin
        w_skip = (mem_rd_data == '0);
    end
`endif

    // Retire the current address: skipped zero word or accepted dump word
    always_comb begin
        w_last    = (r_addr == c_LAST_ADDR);
        w_advance = ((r_state == ST_DUMP_WAIT) && w_skip) ||
                    ((r_state == ST_DUMP_OUT) && dump_ready);
        finished  = w_advance && w_last;
    end

    // Scan sequencer: read, wait for data, optionally present, advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_dump_addr <= '0;
            r_dump_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_addr  <= '0;
                        r_state <= ST_DUMP_RD;
                    end
                end
                ST_DUMP_RD: begin
                    r_state <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (w_skip) begin
                        // The address never wraps: the last one ends the scan
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= ST_DUMP_RD;
                        end
                    end else begin
                        r_dump_addr <= r_addr;
                        r_dump_data <= mem_rd_data;
                        r_state     <= ST_DUMP_OUT;
                    end
                end
                ST_DUMP_OUT: begin
                    if (dump_ready) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= ST_DUMP_RD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registers, so dump_valid has no path
    // from dump_ready
    always_comb begin
        mem_rd_en   = (r_state == ST_DUMP_RD);
        mem_rd_addr = r_addr;
        dump_valid  = (r_state == ST_DUMP_OUT);
        dump_addr   = r_dump_addr;
        dump_data   = r_dump_data;
    end

endmodule : cpu_mon_dump_scanner
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_monitor
//  Description : Run-control and result-dump engine for the 16-bit core.
//                Holds the core in reset for RESET_CYCLES, runs it while
//                counting cycles until a halt encoding (or TIMEOUT) is seen,
//                drains the pipeline for DRAIN_CYCLES and then hands off to
//                the dump scanner, which streams data memory out.
//  Config      : CPU_MON_DUMP_ALL_EN - dump every word (see scanner)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DUMP_DEPTH   = 2**ADDR_W,
    parameter int unsigned       RESET_CYCLES = 4,
    parameter int unsigned       DRAIN_CYCLES = 10,
    parameter int unsigned       TIMEOUT      = 0,
    parameter logic [DATA_W-1:0] HALT_OP_A    = DATA_W'(c_HALT_OP_A_DEFAULT),
    parameter logic [DATA_W-1:0] HALT_OP_B    = DATA_W'(c_HALT_OP_B_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    instr,
    input  logic                 instr_valid,
    output logic                 cpu_reset,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [DATA_W-1:0]    mem_rd_data,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [ADDR_W-1:0]    dump_addr,
    output logic [DATA_W-1:0]    dump_data,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [c_CYCLE_W-1:0] cycle_count
);

    localparam logic [c_CYCLE_W-1:0] c_RESET_LAST   = c_CYCLE_W'(RESET_CYCLES - 1);
    localparam logic [c_CYCLE_W-1:0] c_DRAIN_LAST   = c_CYCLE_W'(DRAIN_CYCLES - 1);
    localparam logic [c_CYCLE_W-1:0] c_TIMEOUT_LAST = c_CYCLE_W'(TIMEOUT - 1);

    // r_state uses ST_DUMP_RD to mean "scanner owns the dump phase"
    cpu_mon_state_e       r_state;
    cpu_mon_state_e       w_state_nxt;
    logic [c_CYCLE_W-1:0] r_cnt;
    logic [c_CYCLE_W-1:0] r_cycle_count;
    logic                 r_timed_out;

    logic w_halt;
    logic w_timeout;
    logic w_dump_go;
    logic w_scan_finished;

    // Halt / timeout qualification for the current RUN cycle
    always_comb begin
        w_halt    = instr_valid && ((instr == HALT_OP_A) || (instr == HALT_OP_B));
        // Fires on the cycle whose edge brings cycle_count to TIMEOUT
        w_timeout = (TIMEOUT != 0) && (r_cycle_count == c_TIMEOUT_LAST);
    end

    // Next-state logic; w_dump_go launches the scanner on entry to the dump
    always_comb begin
        w_state_nxt = r_state;
        w_dump_go   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RESET;
                end
            end
            ST_RESET: begin
                if (r_cnt == c_RESET_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_halt || w_timeout) begin
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nxt = ST_DUMP_RD;
                        w_dump_go   = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = ST_DUMP_RD;
                    w_dump_go   = 1'b1;
                end
            end
            ST_DUMP_RD: begin
                if (w_scan_finished) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, phase counter, run-cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_cnt         <= '0;
                        r_cycle_count <= '0;
                        r_timed_out   <= 1'b0;
                    end
                end
                ST_RESET: begin
                    r_cnt <= (r_cnt == c_RESET_LAST) ? '0 : r_cnt + 1'b1;
                end
                ST_RUN: begin
                    r_cnt <= '0;
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    // A halt on the timeout cycle wins: no timeout flagged
                    if (w_timeout && !w_halt) begin
                        r_timed_out <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        cpu_reset   = (r_state == ST_IDLE) || (r_state == ST_RESET) || (r_state == ST_DONE);
        busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done        = (r_state == ST_DONE);
        timed_out   = r_timed_out;
        cycle_count = r_cycle_count;
    end

    cpu_mon_dump_scanner #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DUMP_DEPTH (DUMP_DEPTH)
    ) u_scanner (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (w_dump_go),
        .finished    (w_scan_finished),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data)
    );

endmodule : cpu_run_monitor
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_monitor
//  Description : Self-checking bench for cpu_run_monitor. A table of runs
//                (halt cycle, halt opcode, expected count/timeout) drives the
//                full reset/run/drain/dump sequence; hand-written sequences
//                cover backpressure, ignored start and asynchronous abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_monitor;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int DEPTH     = 8;
    localparam int RST_CYC   = 4;
    localparam int DRAIN_CYC = 10;
    localparam int TMO       = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              cpu_reset;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [31:0]       cycle_count;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DUMP_DEPTH   (DEPTH),
        .RESET_CYCLES (RST_CYC),
        .DRAIN_CYCLES (DRAIN_CYC),
        .TIMEOUT      (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cpu_reset   (cpu_reset),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    // Data memory with one-cycle read latency
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[2:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected dump stream, derived from the memory image
    logic [ADDR_W-1:0] exp_addr [0:DEPTH-1];
    logic [DATA_W-1:0] exp_data [0:DEPTH-1];
    int                exp_n;

    typedef struct {
        int          halt_cycle;   // 0 = never halt
        logic [15:0] op;
        bit          stall;        // hold dump_ready low 5 cycles on address 4
        bit          poke_start;   // pulse start mid-run
        int          exp_count;
        logic        exp_to;
    } run_t;

    run_t runs [0:3];

    task automatic do_run(input run_t r);
        int                cnt;
        int                n_run;
        int                guard;
        int                got_n;
        int                stalls;
        logic [ADDR_W-1:0] got_addr [0:15];
        logic [DATA_W-1:0] got_data [0:15];
        logic [ADDR_W-1:0] hold_a;
        logic [DATA_W-1:0] hold_d;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_clears_count", cycle_count, 0);
        chk("start_clears_timeout", timed_out, 0);
        chk("busy_in_reset", busy, 1);
        chk("done_low_in_reset", done, 0);

        cnt = 0;
        while (cpu_reset && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("reset_len", cnt, RST_CYC);

        n_run = (r.halt_cycle == 0) ? TMO : r.halt_cycle;
        for (int k = 1; k <= n_run; k++) begin
            if (k == r.halt_cycle) begin
                instr_valid = 1'b1; instr = r.op;
            end else if (k == 2) begin
                instr_valid = 1'b0; instr = 16'hE000;   // halt word but not valid
            end else begin
                instr_valid = 1'b1; instr = 16'(32'h1000 + k);
            end
            if (r.poke_start && k == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (r.poke_start && k == 3) chk("start_ignored_in_run", cpu_reset, 0);
        end
        instr_valid = 1'b0; instr = '0;

        chk("run_cycle_count", cycle_count, r.exp_count);
        chk("run_timed_out", timed_out, r.exp_to);
        chk("cpu_reset_in_drain", cpu_reset, 0);

        cnt = 0;
        while (!mem_rd_en && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("drain_len", cnt, DRAIN_CYC);

        got_n = 0; stalls = 0; guard = 0;
        hold_a = '0; hold_d = '0;
        while (!done && guard < 500) begin
            guard++;
            if (dump_valid) begin
                if (r.stall && dump_addr == 16'd4 && stalls < 5) begin
                    if (stalls == 0) begin
                        hold_a = dump_addr; hold_d = dump_data;
                    end else begin
                        chk("stall_valid_held", dump_valid, 1);
                        chk("stall_addr_stable", dump_addr, hold_a);
                        chk("stall_data_stable", dump_data, hold_d);
                    end
                    dump_ready = 1'b0;
                    stalls++;
                end else begin
                    dump_ready = 1'b1;
                    if (got_n < 16) begin
                        got_addr[got_n] = dump_addr;
                        got_data[got_n] = dump_data;
                    end
                    got_n++;
                end
            end else begin
                dump_ready = 1'b0;
            end
            @(negedge clk);
        end
        dump_ready = 1'b0;

        chk("done_reached", done, 1);
        chk("dump_word_count", got_n, exp_n);
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            chk("dump_addr", got_addr[i], exp_addr[i]);
            chk("dump_data", got_data[i], exp_data[i]);
        end
        if (r.stall) chk("stall_cycles_seen", stalls, 5);
        chk("done_cpu_reset", cpu_reset, 1);
        chk("done_busy", busy, 0);
        chk("done_count_held", cycle_count, r.exp_count);
        chk("done_timed_out", timed_out, r.exp_to);
        @(negedge clk);
        chk("done_count_stable", cycle_count, r.exp_count);
    endtask

    initial begin
        int guard;

        mem[0] = 16'd0; mem[1] = 16'd5; mem[2] = 16'd0; mem[3] = 16'd0;
        mem[4] = 16'd9; mem[5] = 16'd0; mem[6] = 16'd0; mem[7] = 16'd3;

        exp_n = 0;
        for (int a = 0; a < DEPTH; a++) begin
`ifdef CPU_MON_DUMP_ALL_EN
            exp_addr[exp_n] = 16'(a); exp_data[exp_n] = mem[a]; exp_n++;
`else
            if (mem[a] != 16'd0) begin
                exp_addr[exp_n] = 16'(a); exp_data[exp_n] = mem[a]; exp_n++;
            end
`endif
        end

        //            halt  op        stall poke count timeout
        runs[0] = '{  8, 16'hE000, 1'b1, 1'b1,  8, 1'b0 };
        runs[1] = '{  5, 16'hE7FF, 1'b0, 1'b0,  5, 1'b0 };
        runs[2] = '{  0, 16'h0000, 1'b0, 1'b0, 20, 1'b1 };
        runs[3] = '{ 20, 16'hE000, 1'b0, 1'b0, 20, 1'b0 };

        reset_n = 1'b0; start = 1'b0; instr = '0; instr_valid = 1'b0; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) do_run(runs[i]);

        // Abort during DUMP_OUT: halt immediately, wait for the first word
        @(negedge clk); start = 1'b1; instr_valid = 1'b1; instr = 16'hE000;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (!dump_valid && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        chk("abort_reached_dump_out", dump_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_dump_valid", dump_valid, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_rd_en", mem_rd_en, 0);
        chk("abort_cycle_count", cycle_count, 0);
        chk("abort_dump_addr", dump_addr, 0);
        chk("abort_dump_data", dump_data, 0);
        @(negedge clk); reset_n = 1'b1; instr_valid = 1'b0; instr = '0;
        repeat (5) @(negedge clk);
        chk("abort_stays_idle_busy", busy, 0);
        chk("abort_stays_idle_cpu_reset", cpu_reset, 1);
        chk("abort_stays_idle_valid", dump_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_cpu_run_monitor
`default_nettype wire
